// File: rtl/dp_ram_pkg.sv
// Shared types, read-during-write mode codes and the lane-merge helper for dp_ram_ctrl.
package dp_ram_pkg;

  localparam int unsigned MERGE_W  = 64;
  localparam int unsigned MERGE_IW = $clog2(MERGE_W);

  localparam int unsigned RD_READ_FIRST  = 0;
  localparam int unsigned RD_WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Replace every lane of old whose enable bit is set with the matching lane of din.
  // Operands are zero-extended to MERGE_W; lane is the lane width in bits.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0] old,
                                               input logic [MERGE_W-1:0] din,
                                               input logic [MERGE_W-1:0] be,
                                               input int unsigned        lane);
    logic [MERGE_W-1:0] res;
    res = old;
    for (int unsigned j = 0; j < MERGE_W; j++) begin
      if (be[MERGE_IW'(j / lane)]) res[MERGE_IW'(j)] = din[MERGE_IW'(j)];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_ctrl_if.sv
// Request/response bundle for both RAM ports plus the clear handshake.
interface dp_ram_ctrl_if #(
  parameter int unsigned ADDR = 4,
  parameter int unsigned DATA = 8,
  parameter int unsigned NL   = 1
);

  logic            clr;
  logic            busy;
  logic            a_en;
  logic            a_wr;
  logic [NL-1:0]   a_be;
  logic [ADDR-1:0] a_addr;
  logic [DATA-1:0] a_din;
  logic [DATA-1:0] a_dout;
  logic            a_valid;
  logic            b_en;
  logic            b_wr;
  logic [NL-1:0]   b_be;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_din;
  logic [DATA-1:0] b_dout;
  logic            b_valid;
  logic            collision;

  modport master (
    output clr, a_en, a_wr, a_be, a_addr, a_din, b_en, b_wr, b_be, b_addr, b_din,
    input  busy, a_dout, a_valid, b_dout, b_valid, collision
  );

  modport slave (
    input  clr, a_en, a_wr, a_be, a_addr, a_din, b_en, b_wr, b_be, b_addr, b_din,
    output busy, a_dout, a_valid, b_dout, b_valid, collision
  );

endinterface

// File: rtl/dp_ram_outpipe.sv
// Per-port response register: valid pulse, held data and a sideband bit, with optional extra stage.
module dp_ram_outpipe #(
  parameter int unsigned DATA    = 8,
  parameter int unsigned OUT_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  input  logic            in_side,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  output logic            out_side
);

  logic            s1_valid_q;
  logic            s1_side_q;
  logic [DATA-1:0] s1_data_q;

  // First stage: data only advances on an accepted access so it holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_side_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_side_q  <= in_valid & in_side;
      if (in_valid) s1_data_q <= in_data;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic            s2_valid_q;
    logic            s2_side_q;
    logic [DATA-1:0] s2_data_q;

    // Optional second stage, same hold behaviour as the first.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_side_q  <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_side_q  <= s1_side_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_side  = s2_side_q;
    assign out_data  = s2_data_q;
  end else begin : g_noreg
    assign out_valid = s1_valid_q;
    assign out_side  = s1_side_q;
    assign out_data  = s1_data_q;
  end

endmodule

// File: rtl/dp_ram_ctrl.sv
// True dual-port RAM with lane enables, read-during-write policy and a zeroing sweep engine.
module dp_ram_ctrl
  import dp_ram_pkg::*;
#(
  parameter int unsigned ADDR    = 4,
  parameter int unsigned DATA    = 8,
  parameter int unsigned LANE    = 8,
  parameter int unsigned RD_MODE = 0,
  parameter int unsigned OUT_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  dp_ram_ctrl_if.slave  bus
);

  localparam int unsigned NL    = DATA / LANE;
  localparam int unsigned DEPTH = 2 ** ADDR;

  state_e          state_q, state_d;
  logic [ADDR-1:0] ptr_q, ptr_d;
  logic [DATA-1:0] mem [DEPTH];

  logic            clearing_c, idle_c;
  logic            a_acc_c, b_acc_c, a_wacc_c, b_wacc_c, same_c, coll_c;
  logic [DATA-1:0] a_old_c, b_old_c, a_fin_c, b_fin_c, a_res_c, b_res_c;
  logic            wa_en_c;
  logic [ADDR-1:0] wa_addr_c;
  logic [DATA-1:0] wa_data_c;
  logic            a_side_q, b_side_q;

  function automatic logic [DATA-1:0] lane_merge(input logic [DATA-1:0] old,
                                                 input logic [DATA-1:0] din,
                                                 input logic [NL-1:0]   be);
    return DATA'(merge(MERGE_W'(old), MERGE_W'(din), MERGE_W'(be), LANE));
  endfunction

  // State and sweep pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep walks every address once, then idles until a clear request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + ADDR'(1);
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.clr) begin
          ptr_d   = '0;
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Access acceptance, final merged words (B then A, so A wins shared lanes) and port results.
  always_comb begin
    clearing_c = (state_q == CLEAR) && !rst;
    idle_c     = (state_q == IDLE) && !rst;
    a_acc_c    = bus.a_en && idle_c;
    b_acc_c    = bus.b_en && idle_c;
    a_wacc_c   = a_acc_c && bus.a_wr;
    b_wacc_c   = b_acc_c && bus.b_wr;
    same_c     = (bus.a_addr == bus.b_addr);
    coll_c     = a_wacc_c && b_wacc_c && same_c && ((bus.a_be & bus.b_be) != '0);

    a_old_c = mem[bus.a_addr];
    b_old_c = mem[bus.b_addr];

    a_fin_c = a_old_c;
    if (b_wacc_c && same_c) a_fin_c = lane_merge(a_fin_c, bus.b_din, bus.b_be);
    if (a_wacc_c)           a_fin_c = lane_merge(a_fin_c, bus.a_din, bus.a_be);

    b_fin_c = b_old_c;
    if (b_wacc_c)           b_fin_c = lane_merge(b_fin_c, bus.b_din, bus.b_be);
    if (a_wacc_c && same_c) b_fin_c = lane_merge(b_fin_c, bus.a_din, bus.a_be);

    a_res_c = (RD_MODE == RD_WRITE_FIRST) ? a_fin_c : a_old_c;
    b_res_c = (RD_MODE == RD_WRITE_FIRST) ? b_fin_c : b_old_c;

    wa_en_c   = clearing_c || a_wacc_c;
    wa_addr_c = clearing_c ? ptr_q : bus.a_addr;
    wa_data_c = clearing_c ? '0 : a_fin_c;
  end

  // Array writes; on a shared address both ports carry the identical merged word.
  always_ff @(posedge clk) begin
    if (wa_en_c)  mem[wa_addr_c]  <= wa_data_c;
    if (b_wacc_c) mem[bus.b_addr] <= b_fin_c;
  end

  dp_ram_outpipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_acc_c),
    .in_data   (a_res_c),
    .in_side   (coll_c),
    .out_valid (bus.a_valid),
    .out_data  (bus.a_dout),
    .out_side  (a_side_q)
  );

  dp_ram_outpipe #(.DATA(DATA), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_acc_c),
    .in_data   (b_res_c),
    .in_side   (1'b0),
    .out_valid (bus.b_valid),
    .out_data  (bus.b_dout),
    .out_side  (b_side_q)
  );

  // collision rides port A's pipe; B's sideband is tied low.
  assign bus.collision = a_side_q | b_side_q;
  assign bus.busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Bench for dp_ram_ctrl: read-first/1-cycle and write-first/2-cycle instances on shared stimulus.
module tb_dp_ram_ctrl;

  localparam int unsigned ADDR  = 4;
  localparam int unsigned DATA  = 16;
  localparam int unsigned LANE  = 8;
  localparam int unsigned NL    = DATA / LANE;
  localparam int unsigned DEPTH = 2 ** ADDR;

  logic            clk;
  logic            rst;
  logic            clr;
  logic            a_en, a_wr, b_en, b_wr;
  logic [NL-1:0]   a_be, b_be;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_din, b_din;

  int n_checks;
  int n_fail;

  dp_ram_ctrl_if #(.ADDR(ADDR), .DATA(DATA), .NL(NL)) if0 ();
  dp_ram_ctrl_if #(.ADDR(ADDR), .DATA(DATA), .NL(NL)) if1 ();

  assign if0.clr = clr;       assign if1.clr = clr;
  assign if0.a_en = a_en;     assign if1.a_en = a_en;
  assign if0.a_wr = a_wr;     assign if1.a_wr = a_wr;
  assign if0.a_be = a_be;     assign if1.a_be = a_be;
  assign if0.a_addr = a_addr; assign if1.a_addr = a_addr;
  assign if0.a_din = a_din;   assign if1.a_din = a_din;
  assign if0.b_en = b_en;     assign if1.b_en = b_en;
  assign if0.b_wr = b_wr;     assign if1.b_wr = b_wr;
  assign if0.b_be = b_be;     assign if1.b_be = b_be;
  assign if0.b_addr = b_addr; assign if1.b_addr = b_addr;
  assign if0.b_din = b_din;   assign if1.b_din = b_din;

  dp_ram_ctrl #(.ADDR(ADDR), .DATA(DATA), .LANE(LANE), .RD_MODE(0), .OUT_REG(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  dp_ram_ctrl #(.ADDR(ADDR), .DATA(DATA), .LANE(LANE), .RD_MODE(1), .OUT_REG(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: memory image, remaining busy cycles and expected outputs.
  typedef struct packed {
    logic            av;
    logic [DATA-1:0] ad;
    logic            bv;
    logic [DATA-1:0] bd;
    logic            col;
  } obs_t;

  logic [DATA-1:0] mem_m [DEPTH];
  int              busy_cnt;
  bit              model_ready;
  obs_t            e0, e1, p1;
  logic [DATA-1:0] m_olda, m_oldb, m_newa, m_newb;
  logic            m_aa, m_ba, m_col;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    clr = 1'b0;
    a_en = 1'b0; a_wr = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_wr = 1'b0; b_be = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic acc_a(input logic wr, input logic [NL-1:0] be, input logic [ADDR-1:0] addr,
                       input logic [DATA-1:0] din);
    a_en = 1'b1; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic acc_b(input logic wr, input logic [NL-1:0] be, input logic [ADDR-1:0] addr,
                       input logic [DATA-1:0] din);
    b_en = 1'b1; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
  endtask

  // Count rising edges until busy is seen low; optionally pulse clr after edge pulse_at.
  task automatic count_busy(input int pulse_at, output int cnt, output bit seen);
    bit done;
    cnt = 0; seen = 1'b0; done = 1'b0;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      clr = (cnt == pulse_at);
      seen = seen | if0.a_valid | if0.b_valid | if1.a_valid | if1.b_valid;
      if (!if0.busy) done = 1'b1;
    end
    clr = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  seen;
    n_checks = 0;
    n_fail = 0;
    model_ready = 1'b0;
    busy_cnt = 0;
    e0 = '0; e1 = '0; p1 = '0;
    idle_in();
    rst = 1'b1;

    fork
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
      begin : model
        forever begin
          @(posedge clk);
          if (rst) begin
            busy_cnt = DEPTH;
            e0 = '0; e1 = '0; p1 = '0;
            model_ready = 1'b1;
          end else begin
            m_aa = 1'b0; m_ba = 1'b0; m_col = 1'b0;
            m_olda = '0; m_oldb = '0; m_newa = '0; m_newb = '0;
            if (busy_cnt > 0) begin
              busy_cnt--;
              if (busy_cnt == 0) for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end else begin
              m_aa = a_en;
              m_ba = b_en;
              m_olda = mem_m[a_addr];
              m_oldb = mem_m[b_addr];
              if (b_en && b_wr)
                for (int l = 0; l < NL; l++)
                  if (b_be[l]) mem_m[b_addr][l*LANE +: LANE] = b_din[l*LANE +: LANE];
              if (a_en && a_wr)
                for (int l = 0; l < NL; l++)
                  if (a_be[l]) mem_m[a_addr][l*LANE +: LANE] = a_din[l*LANE +: LANE];
              m_newa = mem_m[a_addr];
              m_newb = mem_m[b_addr];
              m_col = a_en && a_wr && b_en && b_wr && (a_addr == b_addr) && ((a_be & b_be) != '0);
              if (clr) busy_cnt = DEPTH;
            end
            // read-first, one-cycle latency
            e0.av = m_aa;  if (m_aa) e0.ad = m_olda;
            e0.bv = m_ba;  if (m_ba) e0.bd = m_oldb;
            e0.col = m_col;
            // write-first, two-cycle latency
            e1.av = p1.av; if (p1.av) e1.ad = p1.ad;
            e1.bv = p1.bv; if (p1.bv) e1.bd = p1.bd;
            e1.col = p1.col;
            p1.av = m_aa; p1.ad = m_newa; p1.bv = m_ba; p1.bd = m_newb; p1.col = m_col;
          end
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (model_ready) begin
            chk1("u0_busy", if0.busy, busy_cnt != 0);
            chk1("u0_a_valid", if0.a_valid, e0.av);
            chkd("u0_a_dout", if0.a_dout, e0.ad);
            chk1("u0_b_valid", if0.b_valid, e0.bv);
            chkd("u0_b_dout", if0.b_dout, e0.bd);
            chk1("u0_collision", if0.collision, e0.col);
            chk1("u1_busy", if1.busy, busy_cnt != 0);
            chk1("u1_a_valid", if1.a_valid, e1.av);
            chkd("u1_a_dout", if1.a_dout, e1.ad);
            chk1("u1_b_valid", if1.b_valid, e1.bv);
            chkd("u1_b_dout", if1.b_dout, e1.bd);
            chk1("u1_collision", if1.collision, e1.col);
          end
        end
      end
    join_none

    // Reset with port A continuously reading address 3.
    acc_a(1'b0, '0, 4'd3, '0);
    repeat (3) @(negedge clk);
    chk1("reset_busy", if0.busy, 1'b1);
    chk1("reset_valid", if0.a_valid, 1'b0);
    chkd("reset_dout", if0.a_dout, 16'h0000);
    rst = 1'b0;
    count_busy(-1, cnt, seen);
    chki("reset_sweep_len", cnt, 16);
    chk1("no_valid_during_sweep", seen, 1'b0);
    @(negedge clk);
    chk1("first_idle_cycle_no_valid_yet", if0.a_valid, 1'b0);
    @(negedge clk);
    chk1("first_read_valid", if0.a_valid, 1'b1);
    chkd("first_read_data", if0.a_dout, 16'h0000);

    // Write then read on the other port.
    idle_in(); acc_a(1'b1, 2'b01, 4'd5, 16'h00A5);
    @(negedge clk);
    idle_in(); acc_b(1'b0, '0, 4'd5, '0);
    @(negedge clk);
    idle_in();
    chk1("wr_then_rd_u0_valid", if0.b_valid, 1'b1);
    chkd("wr_then_rd_u0_data", if0.b_dout, 16'h00A5);
    @(negedge clk);
    chk1("wr_then_rd_u1_valid", if1.b_valid, 1'b1);
    chkd("wr_then_rd_u1_data", if1.b_dout, 16'h00A5);

    // Same-cycle write on A, read on B at the same address.
    acc_a(1'b1, 2'b11, 4'd7, 16'h0011);
    @(negedge clk);
    idle_in(); acc_a(1'b1, 2'b11, 4'd7, 16'h003C); acc_b(1'b0, '0, 4'd7, '0);
    @(negedge clk);
    idle_in();
    chkd("rdw_read_first_b", if0.b_dout, 16'h0011);
    chkd("rdw_read_first_a", if0.a_dout, 16'h0011);
    @(negedge clk);
    chkd("rdw_write_first_b", if1.b_dout, 16'h003C);
    chkd("rdw_write_first_a", if1.a_dout, 16'h003C);

    // Dual write, overlapping lane 0.
    acc_a(1'b1, 2'b01, 4'd2, 16'hAAAA); acc_b(1'b1, 2'b11, 4'd2, 16'hBBBB);
    @(negedge clk);
    idle_in();
    chk1("dual_wr_u0_collision", if0.collision, 1'b1);
    chkd("dual_wr_u0_a_old", if0.a_dout, 16'h0000);
    @(negedge clk);
    chk1("dual_wr_u1_collision", if1.collision, 1'b1);
    chkd("dual_wr_u1_a_merged", if1.a_dout, 16'hBBAA);
    chkd("dual_wr_u1_b_merged", if1.b_dout, 16'hBBAA);
    acc_a(1'b0, '0, 4'd2, '0);
    @(negedge clk);
    idle_in();
    chkd("dual_wr_readback", if0.a_dout, 16'hBBAA);

    // Dual write with A's lanes all disabled.
    acc_a(1'b1, 2'b00, 4'd2, 16'hAAAA); acc_b(1'b1, 2'b11, 4'd2, 16'hBBBB);
    @(negedge clk);
    idle_in();
    chk1("noop_wr_collision", if0.collision, 1'b0);
    chk1("noop_wr_valid", if0.a_valid, 1'b1);
    acc_b(1'b0, '0, 4'd2, '0);
    @(negedge clk);
    idle_in();
    chkd("noop_wr_readback", if0.b_dout, 16'hBBBB);

    // Fill with ones, then clear with a second ignored pulse mid-sweep.
    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); acc_a(1'b1, 2'b11, ADDR'(i), 16'hFFFF);
      @(negedge clk);
    end
    idle_in(); acc_b(1'b0, '0, 4'd9, '0);
    @(negedge clk);
    idle_in();
    chkd("fill_readback", if0.b_dout, 16'hFFFF);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk1("clr_busy_rise", if0.busy, 1'b1);
    count_busy(5, cnt, seen);
    chki("clr_sweep_len", cnt, 16);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); acc_a(1'b0, '0, ADDR'(i), '0); acc_b(1'b0, '0, ADDR'(DEPTH - 1 - i), '0);
      @(negedge clk);
      chk1($sformatf("clr_read_valid_%0d", i), if0.a_valid, 1'b1);
      chkd($sformatf("clr_read_zero_%0d", i), if0.a_dout, 16'h0000);
    end
    idle_in();

    // Reset cancels a read still in the two-stage pipe.
    acc_a(1'b0, '0, 4'd5, '0);
    @(negedge clk);
    idle_in();
    chk1("inflight_u0_valid", if0.a_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("inflight_u1_dropped", if1.a_valid, 1'b0);
    chk1("inflight_rst_busy", if1.busy, 1'b1);
    rst = 1'b0;
    count_busy(-1, cnt, seen);
    chki("rst_inflight_sweep_len", cnt, 16);

    // Reset in the middle of a clear sweep restarts it.
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midsweep_rst_busy", if0.busy, 1'b1);
    count_busy(-1, cnt, seen);
    chki("midsweep_rst_sweep_len", cnt, 16);
    chk1("midsweep_no_valid", seen, 1'b0);
    @(negedge clk);
    acc_a(1'b0, '0, 4'd9, '0);
    @(negedge clk);
    idle_in();
    chkd("midsweep_readback", if0.a_dout, 16'h0000);
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
